msrv_32_instr_queue: RTL

MSRV_32_INSTR_QUEUE -- requirements
Module: msrv_32_instr_queue

---
 rtl/msrv_32_instr_queue.sv | 101 ++++++++++
 1 files changed

// File: rtl/msrv_32_instr_queue.sv
// Decoupling queue between fetch and decode: a circular buffer of {pc, instr}
// entries that presents a NOP with all decode fields sliced whenever it is empty or flushed.
module msrv_32_instr_queue #(
   parameter int          DEPTH     = 4,
   parameter int          PC_W      = 32,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic                       ms_riscv32_mp_clk_in,
   input  logic                       ms_riscv32_mp_rst_in,
   input  logic                       flush_in,
   input  logic                       instr_valid_in,
   input  logic [31:0]                instr_in,
   input  logic [PC_W-1:0]            pc_in,
   output logic                       instr_ready_out,
   input  logic                       dec_ready_in,
   output logic                       dec_valid_out,
   output logic [6:0]                 opcode_out,
   output logic [2:0]                 funct3_out,
   output logic [6:0]                 funct7_out,
   output logic [4:0]                 rs1addr_out,
   output logic [4:0]                 rs2addr_out,
   output logic [4:0]                 rdaddr_out,
   output logic [11:0]                csr_addr_out,
   output logic [31:7]                instr_out,
   output logic [PC_W-1:0]            pc_out,
   output logic [$clog2(DEPTH+1)-1:0] count_out
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [31:0]     instr_mem_q [DEPTH];
   logic [PC_W-1:0] pc_mem_q    [DEPTH];

   logic        push, pop;
   logic [31:0] pres_instr;

   assign instr_ready_out = (count_q != FULL_CNT) && !flush_in;
   assign dec_valid_out   = (count_q != '0) && !flush_in;
   assign push            = instr_valid_in && instr_ready_out;
   assign pop             = dec_valid_out && dec_ready_in;

   // Pointers are powers-of-two wide, so the increment wraps DEPTH-1 -> 0 on its own.
   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      if (flush_in) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + PTR_W'(1);
         if (pop)  rptr_d = rptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
      if (ms_riscv32_mp_rst_in) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   // Entry storage keeps its contents across reset and flush; only pointers say what is live.
   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (push) begin
         instr_mem_q[wptr_q] <= instr_in;
         pc_mem_q[wptr_q]    <= pc_in;
      end
   end

   assign pres_instr = dec_valid_out ? instr_mem_q[rptr_q] : NOP_INSTR;

   assign opcode_out   = pres_instr[6:0];
   assign funct3_out   = pres_instr[14:12];
   assign funct7_out   = pres_instr[31:25];
   assign rs1addr_out  = pres_instr[19:15];
   assign rs2addr_out  = pres_instr[24:20];
   assign rdaddr_out   = pres_instr[11:7];
   assign csr_addr_out = pres_instr[31:20];
   assign instr_out    = pres_instr[31:7];
   assign pc_out       = dec_valid_out ? pc_mem_q[rptr_q] : '0;
   assign count_out    = count_q;

endmodule
